// File: rtl/tds_channel_packetizer_if.sv
// Channel FIFO read side and outgoing 32-bit packet stream of the TDS packetizer.
// master = packetizer side, slave = FIFO / downstream arbiter side.
interface tds_channel_packetizer_if;
    logic [119:0] fifo_data;
    logic         fifo_empty;
    logic [9:0]   fifo_count;
    logic         fifo_rd;
    logic [31:0]  m_data;
    logic         m_valid;
    logic         m_last;
    logic         m_ready;

    modport master (
        input  fifo_data, fifo_empty, fifo_count, m_ready,
        output fifo_rd, m_data, m_valid, m_last
    );

    modport slave (
        output fifo_data, fifo_empty, fifo_count, m_ready,
        input  fifo_rd, m_data, m_valid, m_last
    );
endinterface

// File: rtl/tds_channel_packetizer.sv
// Drains 120-bit hit words from one channel FIFO in bursts and frames them as
// header / 4 beats per hit / trailer packets on a 32-bit valid/ready stream.
module tds_channel_packetizer #(
    parameter logic [3:0] CHANNEL_ID     = 4'd0,
    parameter int         MAX_HITS       = 16,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk160,
    input  logic                            reset,
    input  logic                            enable,
    tds_channel_packetizer_if.master        bus,
    output logic [15:0]                     packet_cnt,
    output logic                            busy
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HEADER  = 3'd1;
    localparam logic [2:0] S_READ    = 3'd2;
    localparam logic [2:0] S_LATCH   = 3'd3;
    localparam logic [2:0] S_SEND    = 3'd4;
    localparam logic [2:0] S_TRAILER = 3'd5;

    localparam logic [9:0]  MAX_CNT     = 10'(MAX_HITS);
    localparam logic [7:0]  MAX_NHITS   = 8'(MAX_HITS);
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]   state_q, state_d;
    logic [15:0]  seq_q, seq_d;
    logic [15:0]  timer_q, timer_d;
    logic [15:0]  packet_cnt_q, packet_cnt_d;
    logic [7:0]   remaining_q, remaining_d;
    logic [1:0]   beat_q, beat_d;
    logic [119:0] hit_q, hit_d;

    logic         m_valid, m_last, fifo_rd, xfer, start;
    logic [31:0]  m_data;
    logic [127:0] hit_word;
    logic [7:0]   nhits;

    assign hit_word = {8'h00, hit_q};

    // Outputs decode purely from registered state, so they stay frozen during a stall.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_data  = '0;
        fifo_rd = 1'b0;
        case (state_q)
            S_HEADER: begin
                m_valid = 1'b1;
                m_data  = {8'hA5, CHANNEL_ID, 4'h0, remaining_q, seq_q[7:0]};
            end
            S_READ: fifo_rd = 1'b1;
            S_SEND: begin
                m_valid = 1'b1;
                case (beat_q)
                    2'd0:    m_data = hit_word[127:96];
                    2'd1:    m_data = hit_word[95:64];
                    2'd2:    m_data = hit_word[63:32];
                    default: m_data = hit_word[31:0];
                endcase
            end
            S_TRAILER: begin
                m_valid = 1'b1;
                m_last  = 1'b1;
                m_data  = {8'h5A, 8'h00, seq_q};
            end
            default: ;
        endcase
    end

    always_comb begin
        xfer  = m_valid && bus.m_ready;
        start = enable && !bus.fifo_empty &&
                ((bus.fifo_count >= MAX_CNT) || (timer_q >= TIMEOUT_LIM));
        nhits = (bus.fifo_count >= MAX_CNT) ? MAX_NHITS : bus.fifo_count[7:0];

        state_d      = state_q;
        seq_d        = seq_q;
        timer_d      = timer_q;
        packet_cnt_d = packet_cnt_q;
        remaining_d  = remaining_q;
        beat_d       = beat_q;
        hit_d        = hit_q;

        case (state_q)
            S_IDLE: begin
                if (bus.fifo_empty)
                    timer_d = '0;
                else if (timer_q != 16'hFFFF)
                    timer_d = timer_q + 16'd1;
                if (start) begin
                    remaining_d = nhits;
                    timer_d     = '0;
                    state_d     = S_HEADER;
                end
            end
            S_HEADER: if (xfer) state_d = S_READ;
            S_READ:   state_d = S_LATCH;
            S_LATCH: begin
                // FIFO dout is valid the cycle after the read strobe.
                hit_d   = bus.fifo_data;
                beat_d  = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (xfer) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        remaining_d = remaining_q - 8'd1;
                        state_d     = (remaining_q == 8'd1) ? S_TRAILER : S_READ;
                    end
                end
            end
            S_TRAILER: begin
                if (xfer) begin
                    seq_d        = seq_q + 16'd1;
                    packet_cnt_d = packet_cnt_q + 16'd1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk160) begin
        // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
        if (reset) begin
            state_q      <= S_IDLE;
            seq_q        <= '0;
            timer_q      <= '0;
            packet_cnt_q <= '0;
            remaining_q  <= '0;
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            timer_q      <= timer_d;
            packet_cnt_q <= packet_cnt_d;
            remaining_q  <= remaining_d;
            beat_q       <= beat_d;
        end
    end

    // NOTE: the hit register is a pure data path, always loaded in LATCH before use, so it has no reset.
    always_ff @(posedge clk160) begin
        hit_q <= hit_d;
    end

    assign bus.m_valid = m_valid;
    assign bus.m_last  = m_last;
    assign bus.m_data  = m_data;
    assign bus.fifo_rd = fifo_rd;
    assign packet_cnt  = packet_cnt_q;
    assign busy        = (state_q != S_IDLE);

endmodule
